// File: rtl/syn_acortex_lb_slave_regs.sv
// ---------------------------------------------------------------------------
// syn_acortex_lb_slave_regs
//   Generic ACORTEX Local Bus responder. One instance per sub-block holds the
//   block ID, sticky STATUS with IRQ_MASK, SCRATCH and NUM_CTRL_REGS control
//   registers, and raises a registered level interrupt.
//
//   Register map:
//     0x00 ID (RO)   0x01 STATUS (W1C)   0x02 IRQ_MASK   0x03 SCRATCH
//     0x04 ERR_CNT   (only with SYN_ACORTEX_LB_ERR_CNTR_EN defined)
//     0x10+k CTRL[k]
//   Unmapped addresses ignore writes and read as 0.
//
//   Optional feature macro: SYN_ACORTEX_LB_ERR_CNTR_EN adds an 8-bit
//   saturating error counter for unmapped and simultaneous rd/wr accesses.
//
// Ports:
//   clk_ir, rst_il        clock, asynchronous active-low reset
//   lb_rd_en, lb_wr_en    single-cycle access strobes
//   lb_addr, lb_wr_data   access address / write data
//   lb_wr_valid           write-complete pulse, 1 cycle after the strobe
//   lb_rd_valid/_data     read response, RD_LAT cycles after the strobe
//   ctrl_regs_od          flat control bus, reg k at [k*DATA_W +: DATA_W]
//   ctrl_wr_pulse_od      per-ctrl-reg write pulse, aligned with lb_wr_valid
//   status_evt_id         per-bit STATUS set events
//   irq_od                |(STATUS & IRQ_MASK), registered
// ---------------------------------------------------------------------------
module syn_acortex_lb_slave_regs #(
  parameter int unsigned       LB_ADDR_W     = 8,
  parameter int unsigned       DATA_W        = 16,
  parameter int unsigned       NUM_CTRL_REGS = 4,
  parameter int unsigned       RD_LAT        = 2,
  parameter logic [DATA_W-1:0] BLOCK_ID      = 16'h0C01
) (
  input  logic                            clk_ir,
  input  logic                            rst_il,
  input  logic                            lb_rd_en,
  input  logic                            lb_wr_en,
  input  logic [LB_ADDR_W-1:0]            lb_addr,
  input  logic [DATA_W-1:0]               lb_wr_data,
  output logic                            lb_wr_valid,
  output logic                            lb_rd_valid,
  output logic [DATA_W-1:0]               lb_rd_data,
  output logic [NUM_CTRL_REGS*DATA_W-1:0] ctrl_regs_od,
  output logic [NUM_CTRL_REGS-1:0]        ctrl_wr_pulse_od,
  input  logic [DATA_W-1:0]               status_evt_id,
  output logic                            irq_od
);

  localparam logic [LB_ADDR_W-1:0] ADDR_ID      = LB_ADDR_W'(0);
  localparam logic [LB_ADDR_W-1:0] ADDR_STATUS  = LB_ADDR_W'(1);
  localparam logic [LB_ADDR_W-1:0] ADDR_MASK    = LB_ADDR_W'(2);
  localparam logic [LB_ADDR_W-1:0] ADDR_SCRATCH = LB_ADDR_W'(3);
  localparam logic [LB_ADDR_W-1:0] ADDR_ERR     = LB_ADDR_W'(4);
  localparam logic [LB_ADDR_W-1:0] ADDR_CTRL0   = LB_ADDR_W'(16);

  logic [DATA_W-1:0]        status;
  logic [DATA_W-1:0]        irq_mask;
  logic [DATA_W-1:0]        scratch;
  logic [DATA_W-1:0]        ctrl [NUM_CTRL_REGS];
  logic [NUM_CTRL_REGS-1:0] sel_ctrl;
  logic [DATA_W-1:0]        rd_mux;
  logic [DATA_W-1:0]        status_clr;
  logic                     rd_fire;
  logic [RD_LAT-1:0]        pipe_v;
  logic [DATA_W-1:0]        pipe_d [RD_LAT];

`ifdef SYN_ACORTEX_LB_ERR_CNTR_EN
  logic [7:0] err_cnt;
  logic       unmapped;
  logic       err_evt;
`endif

  // A simultaneous write wins; the read is dropped.
  assign rd_fire = lb_rd_en & ~lb_wr_en;

  // Decode and read mux reflect register state before this edge, so a read
  // and write on the same edge returns the old value.
  always_comb begin
    sel_ctrl = '0;
    rd_mux   = '0;
    for (int unsigned k = 0; k < NUM_CTRL_REGS; k++) begin
      if (lb_addr == ADDR_CTRL0 + LB_ADDR_W'(k)) sel_ctrl[k] = 1'b1;
    end
    case (lb_addr)
      ADDR_ID:      rd_mux = BLOCK_ID;
      ADDR_STATUS:  rd_mux = status;
      ADDR_MASK:    rd_mux = irq_mask;
      ADDR_SCRATCH: rd_mux = scratch;
`ifdef SYN_ACORTEX_LB_ERR_CNTR_EN
      ADDR_ERR:     rd_mux = DATA_W'(err_cnt);
`endif
      default: begin
        for (int unsigned k = 0; k < NUM_CTRL_REGS; k++) begin
          if (sel_ctrl[k]) rd_mux = ctrl[k];
        end
      end
    endcase
  end

  always_comb begin
    status_clr = '0;
    if (lb_wr_en && lb_addr == ADDR_STATUS) status_clr = lb_wr_data;
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      lb_wr_valid      <= 1'b0;
      ctrl_wr_pulse_od <= '0;
      status           <= '0;
      irq_mask         <= '0;
      scratch          <= '0;
      irq_od           <= 1'b0;
      for (int unsigned k = 0; k < NUM_CTRL_REGS; k++) ctrl[k] <= '0;
    end else begin
      lb_wr_valid      <= lb_wr_en;
      ctrl_wr_pulse_od <= lb_wr_en ? sel_ctrl : '0;
      // Event set takes priority over a same-edge W1C.
      status           <= (status & ~status_clr) | status_evt_id;
      irq_od           <= |(status & irq_mask);
      if (lb_wr_en) begin
        if (lb_addr == ADDR_MASK)    irq_mask <= lb_wr_data;
        if (lb_addr == ADDR_SCRATCH) scratch  <= lb_wr_data;
        for (int unsigned k = 0; k < NUM_CTRL_REGS; k++) begin
          if (sel_ctrl[k]) ctrl[k] <= lb_wr_data;
        end
      end
    end
  end

  // Read response pipeline; data is forced to 0 on empty slots so the output
  // bus is 0 whenever lb_rd_valid is low.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      pipe_v <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= rd_fire;
      pipe_d[0] <= rd_fire ? rd_mux : '0;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign lb_rd_valid = pipe_v[RD_LAT-1];
  assign lb_rd_data  = pipe_d[RD_LAT-1];

  always_comb begin
    ctrl_regs_od = '0;
    for (int unsigned k = 0; k < NUM_CTRL_REGS; k++) begin
      ctrl_regs_od[k*DATA_W +: DATA_W] = ctrl[k];
    end
  end

`ifdef SYN_ACORTEX_LB_ERR_CNTR_EN
  assign unmapped = (lb_addr > ADDR_ERR) && !(|sel_ctrl);
  assign err_evt  = (lb_rd_en & lb_wr_en) | ((lb_rd_en | lb_wr_en) & unmapped);

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      err_cnt <= '0;
    end else if (lb_wr_en && lb_addr == ADDR_ERR) begin
      err_cnt <= '0;
    end else if (err_evt && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_syn_acortex_lb_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_syn_acortex_lb_slave_regs
//   Directed scenarios followed by randomized LB traffic, checked every cycle
//   against a register-map reference model. Build with
//   SYN_ACORTEX_LB_ERR_CNTR_EN defined to also cover the error counter.
// ---------------------------------------------------------------------------
module tb_syn_acortex_lb_slave_regs;

  localparam int          LB_ADDR_W = 8;
  localparam int          DATA_W    = 16;
  localparam int          NCR       = 4;
  localparam int          RD_LAT    = 2;
  localparam logic [15:0] BID       = 16'h0C01;

  logic        clk_ir = 1'b0;
  logic        rst_il;
  logic        lb_rd_en, lb_wr_en;
  logic [7:0]  lb_addr;
  logic [15:0] lb_wr_data;
  logic        lb_wr_valid, lb_rd_valid;
  logic [15:0] lb_rd_data;
  logic [63:0] ctrl_regs_od;
  logic [3:0]  ctrl_wr_pulse_od;
  logic [15:0] status_evt_id;
  logic        irq_od;

  always #5 clk_ir = ~clk_ir;

  syn_acortex_lb_slave_regs #(
    .LB_ADDR_W    (LB_ADDR_W),
    .DATA_W       (DATA_W),
    .NUM_CTRL_REGS(NCR),
    .RD_LAT       (RD_LAT),
    .BLOCK_ID     (BID)
  ) dut (
    .clk_ir          (clk_ir),
    .rst_il          (rst_il),
    .lb_rd_en        (lb_rd_en),
    .lb_wr_en        (lb_wr_en),
    .lb_addr         (lb_addr),
    .lb_wr_data      (lb_wr_data),
    .lb_wr_valid     (lb_wr_valid),
    .lb_rd_valid     (lb_rd_valid),
    .lb_rd_data      (lb_rd_data),
    .ctrl_regs_od    (ctrl_regs_od),
    .ctrl_wr_pulse_od(ctrl_wr_pulse_od),
    .status_evt_id   (status_evt_id),
    .irq_od          (irq_od)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [15:0] data;
  } rsp_t;

  logic [15:0] m_status, m_mask, m_scratch;
  logic [15:0] m_ctrl [NCR];
  int          m_err;
  rsp_t        rq[$];
  int          cyc;
  logic        e_wv, e_irq;
  logic [3:0]  e_pulse;

  function automatic bit is_ctrl(input int a);
    return (a >= 16) && (a < 16 + NCR);
  endfunction

  function automatic bit m_mapped(input int a);
`ifdef SYN_ACORTEX_LB_ERR_CNTR_EN
    if (a == 4) return 1'b1;
`endif
    return (a <= 3) || is_ctrl(a);
  endfunction

  function automatic logic [15:0] m_read(input int a);
    if (a == 0) return BID;
    if (a == 1) return m_status;
    if (a == 2) return m_mask;
    if (a == 3) return m_scratch;
`ifdef SYN_ACORTEX_LB_ERR_CNTR_EN
    if (a == 4) return 16'(m_err);
`endif
    if (is_ctrl(a)) return m_ctrl[a-16];
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_status = '0; m_mask = '0; m_scratch = '0; m_err = 0;
    for (int k = 0; k < NCR; k++) m_ctrl[k] = '0;
    rq.delete();
    e_wv = 1'b0; e_irq = 1'b0; e_pulse = '0;
  endtask

  task automatic model_edge(input bit rd, input bit wr, input int a,
                            input logic [15:0] wd, input logic [15:0] evt);
    logic [15:0] clr;
    cyc++;
    e_irq   = |(m_status & m_mask);
    e_wv    = wr;
    e_pulse = '0;
    if (wr && is_ctrl(a)) e_pulse[a-16] = 1'b1;
    if (rd && !wr) rq.push_back('{due: cyc + RD_LAT - 1, data: m_read(a)});
`ifdef SYN_ACORTEX_LB_ERR_CNTR_EN
    if (wr && a == 4) m_err = 0;
    else if ((rd && wr) || ((rd || wr) && !m_mapped(a))) m_err = (m_err < 255) ? m_err + 1 : 255;
`endif
    clr = (wr && a == 1) ? wd : 16'h0000;
    m_status = (m_status & ~clr) | evt;
    if (wr) begin
      if (a == 2) m_mask = wd;
      if (a == 3) m_scratch = wd;
      if (is_ctrl(a)) m_ctrl[a-16] = wd;
    end
  endtask

  task automatic check_outputs();
    logic        e_rv;
    logic [15:0] e_rd;
    logic [63:0] e_flat;
    e_rv = 1'b0; e_rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_rv = 1'b1; e_rd = rq[0].data;
      void'(rq.pop_front());
    end
    for (int k = 0; k < NCR; k++) e_flat[k*16 +: 16] = m_ctrl[k];
    check("wr_valid",  64'(lb_wr_valid),      64'(e_wv));
    check("rd_valid",  64'(lb_rd_valid),      64'(e_rv));
    check("rd_data",   64'(lb_rd_data),       64'(e_rd));
    check("ctrl_pulse",64'(ctrl_wr_pulse_od), 64'(e_pulse));
    check("irq",       64'(irq_od),           64'(e_irq));
    check("ctrl_regs", ctrl_regs_od,          e_flat);
  endtask

  task automatic do_cycle(input bit rd, input bit wr, input int a,
                          input logic [15:0] wd, input logic [15:0] evt);
    @(negedge clk_ir);
    lb_rd_en = rd; lb_wr_en = wr; lb_addr = 8'(a);
    lb_wr_data = wd; status_evt_id = evt;
    @(posedge clk_ir);
    if (rst_il) model_edge(rd, wr, a, wd, evt);
    else        model_reset();
    #1 check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 0, 16'h0000, 16'h0000);
  endtask

  task automatic rd(input int a);
    do_cycle(1'b1, 1'b0, a, 16'h0000, 16'h0000);
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    do_cycle(1'b0, 1'b1, a, d, 16'h0000);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wv"},    64'(lb_wr_valid),      64'(0));
    check({tag, "_rv"},    64'(lb_rd_valid),      64'(0));
    check({tag, "_rd"},    64'(lb_rd_data),       64'(0));
    check({tag, "_irq"},   64'(irq_od),           64'(0));
    check({tag, "_pulse"}, 64'(ctrl_wr_pulse_od), 64'(0));
    check({tag, "_ctrl"},  ctrl_regs_od,          64'(0));
  endtask

  int addr_tbl [12] = '{0, 1, 2, 3, 4, 5, 16, 17, 18, 19, 20, 255};

  initial begin
    rst_il = 1'b0;
    lb_rd_en = 1'b0; lb_wr_en = 1'b0; lb_addr = '0;
    lb_wr_data = '0; status_evt_id = '0;
    cyc = 0;
    model_reset();

    // Reset: all outputs held at 0.
    idle(3);
    check_all_zero("reset");
    @(negedge clk_ir) rst_il = 1'b1;

    // ID read, latency RD_LAT.
    rd(0);
    check("id_early_rv", 64'(lb_rd_valid), 64'(0));
    idle(1);
    check("id_rv",   64'(lb_rd_valid), 64'(1));
    check("id_data", 64'(lb_rd_data),  64'(16'h0C01));

    // Ctrl write, pulse and read-after-write.
    wr(17, 16'hA5A5);
    check("cw_wv",    64'(lb_wr_valid),       64'(1));
    check("cw_pulse", 64'(ctrl_wr_pulse_od),  64'(4'b0010));
    check("cw_bus",   64'(ctrl_regs_od[31:16]), 64'(16'hA5A5));
    rd(17);
    idle(1);
    check("cw_rdback", 64'(lb_rd_data), 64'(16'hA5A5));

    // Back-to-back reads of all ctrl regs.
    wr(16, 16'h1111); wr(18, 16'h3333); wr(19, 16'h4444);
    for (int k = 0; k < NCR; k++) rd(16 + k);
    idle(3);

    // STATUS / IRQ.
    wr(2, 16'h0004);
    do_cycle(1'b0, 1'b0, 0, 16'h0000, 16'h0004);
    idle(1);
    check("irq_set", 64'(irq_od), 64'(1));
    do_cycle(1'b0, 1'b1, 1, 16'h0004, 16'h0004);
    rd(1);
    idle(1);
    check("w1c_set_wins", 64'(lb_rd_data), 64'(16'h0004));
    wr(1, 16'h0004);
    rd(1);
    idle(1);
    check("w1c_clear", 64'(lb_rd_data), 64'(16'h0000));
    idle(2);
    check("irq_clear", 64'(irq_od), 64'(0));

    // Simultaneous read+write: write done, read dropped.
    do_cycle(1'b1, 1'b1, 3, 16'h1234, 16'h0000);
    check("rw_wv", 64'(lb_wr_valid), 64'(1));
    idle(2);
    rd(3);
    idle(1);
    check("rw_scratch", 64'(lb_rd_data), 64'(16'h1234));
    rd(4);
    idle(1);
`ifdef SYN_ACORTEX_LB_ERR_CNTR_EN
    check("err_one", 64'(lb_rd_data), 64'(1));
    for (int i = 0; i < 300; i++) rd(8'h80);
    rd(4);
    idle(1);
    check("err_sat", 64'(lb_rd_data), 64'(16'h00FF));
    wr(4, 16'h0000);
`else
    check("unmapped_04", 64'(lb_rd_data), 64'(0));
`endif

    // Reset with reads in flight.
    rd(0);
    rd(3);
    @(negedge clk_ir);
    rst_il = 1'b0;
    lb_rd_en = 1'b0; lb_wr_en = 1'b0;
    model_reset();
    #1 check_all_zero("mid_reset");
    idle(2);
    @(negedge clk_ir) rst_il = 1'b1;
    idle(3);
    for (int k = 0; k < NCR; k++) rd(16 + k);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int r, a;
      bit brd, bwr;
      logic [15:0] evt;
      r   = int'($urandom_range(99, 0));
      brd = (r < 40);
      bwr = (r >= 30) && (r < 60);
      a   = addr_tbl[$urandom_range(11, 0)];
      evt = ($urandom_range(5, 0) == 0) ? 16'(1 << $urandom_range(15, 0)) : 16'h0000;
      do_cycle(brd, bwr, a, 16'($urandom), evt);
    end
    idle(RD_LAT + 1);
    check("drain", 64'(rq.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/syn_acortex_lb_slave_regs.md
Name: syn_acortex_lb_slave_regs

Overview:
- Generic ACORTEX Local Bus responder: the slave end of the LB fabric, instantiated once per ACORTEX sub-block (clock mux, WM8731 driver, etc.) on that block's LB modport.
- Accepts single-cycle rd_en/wr_en strobes and returns wr_valid/rd_valid pulses.
- Holds the block's ID, sticky status/interrupt, mask, scratch and control registers.
- Exports control values and write pulses to the owning datapath and raises a level interrupt.

Parameters:
- LB_ADDR_W, 8, LB address width.
- DATA_W, 16, register and data width (8..32).
- NUM_CTRL_REGS, 4, number of RW control registers at 0x10..0x10+NUM_CTRL_REGS-1 (1..16).
- RD_LAT, 2, rd_en to rd_valid latency in cycles (1..4).
- BLOCK_ID, 16'h0C01, value of the RO ID register.

Ports:
- clk_ir  in  1  block clock.
- rst_il  in  1  asynchronous active-low reset.
- lb_rd_en  in  1  read strobe, one cycle per access.
- lb_wr_en  in  1  write strobe, one cycle per access.
- lb_addr  in  LB_ADDR_W  access address, valid with either strobe.
- lb_wr_data  in  DATA_W  write data, valid with lb_wr_en.
- lb_wr_valid  out  1  write-complete pulse.
- lb_rd_valid  out  1  read-data-valid pulse.
- lb_rd_data  out  DATA_W  read data, valid only while lb_rd_valid=1, else 0.
- ctrl_regs_od  out  NUM_CTRL_REGS*DATA_W  flat control register bus; reg k at [k*DATA_W +: DATA_W].
- ctrl_wr_pulse_od  out  NUM_CTRL_REGS  one-cycle pulse when ctrl reg k is written.
- status_evt_id  in  DATA_W  per-bit event pulses from the datapath.
- irq_od  out  1  interrupt: OR of (STATUS & IRQ_MASK), registered.

Behaviour:
- Clock and reset: single clock clk_ir; reset rst_il is asynchronous, active-low. While rst_il=0 every flop clears:
  - lb_wr_valid=0, lb_rd_valid=0, lb_rd_data=0, irq_od=0, ctrl_wr_pulse_od=0.
  - All ctrl regs, STATUS, IRQ_MASK and SCRATCH = 0.
  - Read pipeline flushed: reads in flight are dropped, no rd_valid is issued afterwards.
- Register map:
  - 0x00 ID, RO = BLOCK_ID.
  - 0x01 STATUS, write-1-to-clear.
  - 0x02 IRQ_MASK, RW.
  - 0x03 SCRATCH, RW.
  - 0x10+k CTRL[k], RW.
  - Any other address is unmapped: writes are ignored, reads return 0.
- Write:
  - lb_wr_en sampled at edge N; register updated at N; lb_wr_valid=1 for exactly cycle N+1 (latency 1), including unmapped writes and writes to ID.
  - ctrl_wr_pulse_od[k] is high in the same cycle as lb_wr_valid.
- Read:
  - Register value captured at edge N into an RD_LAT-deep shift pipeline (valid bit plus data).
  - lb_rd_valid and lb_rd_data are presented RD_LAT cycles after the strobe.
  - Back-to-back reads every cycle are supported, one response per strobe, in order.
- Read/write ordering:
  - A read issued the cycle after a write to the same address returns the new value.
  - A read and a write to the same register on the same edge returns the old value.
- Simultaneous lb_rd_en and lb_wr_en:
  - The write is performed and the read is dropped (no rd_valid).
  - Counted as a protocol error (see optional feature).
- STATUS bit i:
  - Set when status_evt_id[i]=1; cleared by a write with bit i=1.
  - Set and clear on the same edge: set wins.
- irq_od: registered, one cycle after STATUS/IRQ_MASK change.
- Width rule: writes use lb_wr_data[DATA_W-1:0]; the bus master zero-extends read data.

Optional Feature:
- Macro: SYN_ACORTEX_LB_ERR_CNTR_EN.
- When defined:
  - Register 0x04 ERR_CNT, 8-bit, saturating at 0xFF, zero-extended on reads.
  - Increments on each unmapped access and each simultaneous rd_en+wr_en; both conditions on one edge increment it by 1.
  - Any write to 0x04 clears it.
- When undefined: 0x04 is unmapped and the counter logic is absent.

Test Plan:
- Reset, then read 0x00 -> lb_rd_valid exactly 2 cycles later with lb_rd_data=16'h0C01; all outputs 0 during reset.
- Write 0xA5A5 to 0x11 -> lb_wr_valid and ctrl_wr_pulse_od=4'b0010 one cycle later; ctrl_regs_od[31:16]=0xA5A5; read 0x11 next cycle returns 0xA5A5.
- Reads to 0x10,0x11,0x12,0x13 on 4 consecutive cycles -> 4 consecutive rd_valid pulses with matching data, in order.
- status_evt_id=0x0004 with IRQ_MASK=0x0004 -> STATUS=0x0004, irq_od=1 one cycle later; W1C 0x0004 in the same cycle as a new event -> STATUS stays 0x0004.
- Simultaneous wr_en+rd_en at 0x03 with data 0x1234 -> SCRATCH=0x1234, wr_valid pulse, no rd_valid; with the macro defined ERR_CNT reads 1; 300 unmapped reads -> ERR_CNT=0xFF.
- Assert rst_il low with 2 reads in flight -> no lb_rd_valid after deassertion; ctrl regs read back 0.
